dwconv_add_ctrl: RTL and testbench

- Sequencer for the depthwise-conv bias/add stage. Accepts a stream of partial-sum pairs with valid/ready.
- Drives the add stage's enable and selects a per-channel bias from an internal bias register file.
- Walks channel-major over CHANNELS x PIXELS output positions. Tags each registered sum with its channel and pixel, and signals completion of a full layer pass.

---
 rtl/dwconv_pkg.sv | 21 ++
 rtl/dwconv_bias_regfile.sv | 36 +++
 rtl/dwconv_add_ctrl.sv | 120 ++++++++++++
 tb/tb_dwconv_add_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dwconv_pkg.sv
// Shared types and helpers for the depthwise-conv bias/add controller.
package dwconv_pkg;

    localparam int DWCONV_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dwconv_bias_regfile.sv
// Per-channel bias storage: one gated write port, one combinational read port.
module dwconv_bias_regfile #(
    parameter int CHANNELS = 8,
    parameter int DATA_W   = 32,
    parameter int CH_W     = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              we,
    input  logic [CH_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [CH_W-1:0]   raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] bias_q [CHANNELS];

    // Decoding against each entry index drops out-of-range addresses for free.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < CHANNELS; i++) bias_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (we && (32'(waddr) == i)) bias_q[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (32'(raddr) == i) rdata = bias_q[i];
        end
    end

endmodule

// File: rtl/dwconv_add_ctrl.sv
// Sequencer for the depthwise-conv bias/add stage: walks channel-major over
// CHANNELS x PIXELS, drives add enable/bias and tags each registered sum.
module dwconv_add_ctrl
    import dwconv_pkg::*;
#(
    parameter  int CHANNELS = 8,
    parameter  int PIXELS   = 64,
    parameter  int DATA_W   = DWCONV_DATA_W,
    localparam int CH_W     = clog2_min1(CHANNELS),
    localparam int PIX_W    = clog2_min1(PIXELS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0] cfg_bias,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              add_en,
    output logic [DATA_W-1:0] add_bias,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [PIX_W-1:0]  out_pix,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               out_valid_q, out_valid_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [PIX_W-1:0]   out_pix_q, out_pix_d;
    logic               accept;
    logic               last_pix;
    logic               last_ch;

    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid && in_ready;
    assign last_pix = (pix_q == PIX_W'(PIXELS - 1));
    assign last_ch  = (ch_q == CH_W'(CHANNELS - 1));

    // Bias is frozen outside IDLE so a pass sees one consistent set.
    dwconv_bias_regfile #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W),
        .CH_W     (CH_W)
    ) u_bias (
        .clk   (clk),
        .rst_b (rst_b),
        .we    (cfg_we && (state_q == ST_IDLE)),
        .waddr (cfg_addr),
        .wdata (cfg_bias),
        .raddr (ch_q),
        .rdata (add_bias)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        out_valid_d = accept;
        out_ch_d    = out_ch_q;
        out_pix_d   = out_pix_q;
        if (accept) begin
            out_ch_d  = ch_q;
            out_pix_d = pix_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    ch_d    = '0;
                    pix_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_pix) begin
                        pix_d = '0;
                        if (last_ch) state_d = ST_DRAIN;
                        else         ch_d    = ch_q + 1'b1;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_pix_q   <= out_pix_d;
        end
    end

    assign add_en    = accept;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_pix   = out_pix_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_dwconv_add_ctrl.sv
// Directed bench: a 2x3 controller for pass/stall/config/reset cases and a
// 1x1 controller for minimal sizing and out-of-range bias writes.
module tb_dwconv_add_ctrl;

    localparam logic [31:0] BM7 = 32'hFFFF_FFF9;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cfg_we;
    logic        cfg_addr;
    logic [31:0] cfg_bias;

    logic        start_a, in_valid_a, in_ready_a, add_en_a, out_valid_a, busy_a, done_a;
    logic [31:0] add_bias_a;
    logic        out_ch_a;
    logic [1:0]  out_pix_a;

    logic        start_b, in_valid_b, in_ready_b, add_en_b, out_valid_b, busy_b, done_b;
    logic [31:0] add_bias_b;
    logic        out_ch_b;
    logic        out_pix_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dwconv_add_ctrl #(.CHANNELS(2), .PIXELS(3), .DATA_W(32)) dut_a (
        .clk(clk), .rst_b(rst_b), .start(start_a), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_bias(cfg_bias), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .add_en(add_en_a), .add_bias(add_bias_a),
        .out_valid(out_valid_a), .out_ch(out_ch_a), .out_pix(out_pix_a),
        .busy(busy_a), .done(done_a)
    );

    dwconv_add_ctrl #(.CHANNELS(1), .PIXELS(1), .DATA_W(32)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(start_b), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_bias(cfg_bias), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .add_en(add_en_b), .add_bias(add_bias_b),
        .out_valid(out_valid_b), .out_ch(out_ch_b), .out_pix(out_pix_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, cyc, w;
        logic prev;
        logic [1:0] pch, ppix;

        rst_b = 1'b0; cfg_we = 1'b0; cfg_addr = 1'b0; cfg_bias = '0;
        start_a = 1'b0; in_valid_a = 1'b1; start_b = 1'b0; in_valid_b = 1'b0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_add_en",   add_en_a, 0);
        chk("rst_busy",     busy_a, 0);
        chk("rst_done",     done_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_add_bias", add_bias_a, 0);
        rst_b = 1'b1; in_valid_a = 1'b0;

        // bias load
        @(negedge clk); cfg_we = 1'b1; cfg_addr = 1'b0; cfg_bias = 32'd5;
        @(negedge clk); cfg_addr = 1'b1; cfg_bias = BM7;
        @(negedge clk); cfg_we = 1'b0; start_a = 1'b1;

        // pass 1: continuous valid
        @(negedge clk); start_a = 1'b0; in_valid_a = 1'b1;
        chk("p1_in_ready", in_ready_a, 1);
        chk("p1_busy", busy_a, 1);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("p1_add_en", add_en_a, 1);
            chk("p1_add_bias", add_bias_a, (k < 3) ? 32'd5 : BM7);
            if (k > 0) begin
                chk("p1_out_valid", out_valid_a, 1);
                chk("p1_out_ch",  out_ch_a,  (k - 1) / 3);
                chk("p1_out_pix", out_pix_a, (k - 1) % 3);
            end
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        chk("p1_drain_valid", out_valid_a, 1);
        chk("p1_drain_ch",  out_ch_a, 1);
        chk("p1_drain_pix", out_pix_a, 2);
        chk("p1_drain_busy", busy_a, 1);
        chk("p1_drain_ready", in_ready_a, 0);
        chk("p1_drain_done", done_a, 0);
        @(negedge clk);
        chk("p1_done", done_a, 1);
        chk("p1_done_busy", busy_a, 0);
        chk("p1_done_ov", out_valid_a, 0);
        @(negedge clk);
        chk("p1_idle_done", done_a, 0);

        // pass 2: stalls, locked config write and start mid-pass
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        n = 0; cyc = 0; prev = 1'b0; pch = '0; ppix = '0;
        while (n < 6 && cyc < 40) begin
            in_valid_a = (cyc % 3 == 0);
            start_a = (cyc == 1);
            cfg_we = (cyc == 1); cfg_addr = 1'b0; cfg_bias = 32'd99;
            #1;
            chk("p2_add_en", add_en_a, in_valid_a);
            chk("p2_add_bias", add_bias_a, (n < 3) ? 32'd5 : BM7);
            chk("p2_out_valid", out_valid_a, prev);
            if (prev) begin
                chk("p2_out_ch", out_ch_a, pch);
                chk("p2_out_pix", out_pix_a, ppix);
            end
            prev = in_valid_a;
            if (in_valid_a) begin
                pch = 2'(n / 3); ppix = 2'(n % 3); n++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid_a = 1'b0; start_a = 1'b0; cfg_we = 1'b0;
        chk("p2_drain_valid", out_valid_a, 1);
        chk("p2_drain_ch", out_ch_a, 1);
        chk("p2_drain_pix", out_pix_a, 2);
        chk("p2_drain_busy", busy_a, 1);
        @(negedge clk);
        chk("p2_done", done_a, 1);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("p2_idle_done", done_a, 0);
        chk("p2_idle_busy", busy_a, 0);
        chk("p2_idle_ready", in_ready_a, 0);
        @(negedge clk);
        chk("p2_idle_ready2", in_ready_a, 0);

        // pass 3: write+start together, then reset after two accepts
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_bias = 32'd99; start_a = 1'b1;
        @(negedge clk); cfg_we = 1'b0; start_a = 1'b0; in_valid_a = 1'b1;
        #1 chk("p3_bias99", add_bias_a, 32'd99);
        @(negedge clk); @(negedge clk);
        chk("p3_ov", out_valid_a, 1);
        chk("p3_pix", out_pix_a, 1);
        #2 rst_b = 1'b0;
        #1;
        chk("p3_rst_ov", out_valid_a, 0);
        chk("p3_rst_busy", busy_a, 0);
        chk("p3_rst_ready", in_ready_a, 0);
        chk("p3_rst_done", done_a, 0);
        chk("p3_rst_add_en", add_en_a, 0);
        chk("p3_rst_bias", add_bias_a, 0);
        @(negedge clk); rst_b = 1'b1; in_valid_a = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; in_valid_a = 1'b1;
        #1;
        chk("p3_restart_bias", add_bias_a, 0);
        chk("p3_restart_en", add_en_a, 1);
        @(negedge clk);
        chk("p3_restart_ov", out_valid_a, 1);
        chk("p3_restart_ch", out_ch_a, 0);
        chk("p3_restart_pix", out_pix_a, 0);
        w = 0;
        while (!done_a && w < 20) begin
            @(negedge clk); w++;
        end
        chk("p3_done", done_a, 1);
        in_valid_a = 1'b0;

        // 1x1 controller: out-of-range write ignored, single-beat pass
        @(negedge clk); cfg_we = 1'b1; cfg_addr = 1'b0; cfg_bias = 32'd42;
        @(negedge clk); cfg_addr = 1'b1; cfg_bias = 32'd123;
        @(negedge clk); cfg_we = 1'b0;
        #1 chk("b_oor_write", add_bias_b, 32'd42);
        start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        chk("b_ready", in_ready_b, 1);
        chk("b_busy", busy_b, 1);
        chk("b_bias", add_bias_b, 32'd42);
        in_valid_b = 1'b1;
        #1 chk("b_add_en", add_en_b, 1);
        @(negedge clk); in_valid_b = 1'b0;
        chk("b_drain_ov", out_valid_b, 1);
        chk("b_drain_ch", out_ch_b, 0);
        chk("b_drain_pix", out_pix_b, 0);
        chk("b_drain_busy", busy_b, 1);
        chk("b_drain_ready", in_ready_b, 0);
        @(negedge clk);
        chk("b_done", done_b, 1);
        chk("b_done_ov", out_valid_b, 0);
        @(negedge clk);
        chk("b_idle_done", done_b, 0);
        chk("b_idle_busy", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
